// File: rtl/aes_pkg.sv
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants, instruction field offsets and width helpers
//               for the AES request path (aes_req_queue, aes_fsm).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  // Default address width of each instruction field
  localparam int AES_ADDRW = 24;

  // Instruction field offsets at the default address width
  localparam int MODE_BIT = 3 * AES_ADDRW + 1;
  localparam int RSVD_BIT = 3 * AES_ADDRW;
  localparam int KEY_LSB  = 2 * AES_ADDRW;
  localparam int TEXT_LSB = AES_ADDRW;
  localparam int DEST_LSB = 0;

  // Requester identifiers shared with aes_fsm
  localparam logic [1:0] ACCEL_ID = 2'd0;
  localparam logic [1:0] MEM_ID   = 2'd1;

  // Full instruction width: three address fields plus mode and reserved bits
  function automatic int instr_width(input int addrw);
    return 3 * addrw + 2;
  endfunction

  // Number of host bytes needed to carry one instruction
  function automatic int nbytes(input int instrw);
    return (instrw + 7) / 8;
  endfunction

endpackage : aes_pkg

`default_nettype wire

// File: rtl/aes_req_queue_if.sv
// ============================================================================
// Module      : aes_req_queue_if
// Description : Host byte stream and AES request handshake bundle for
//               aes_req_queue. master = host/consumer side, slave = queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_req_queue_if
  import aes_pkg::*;
#(
  parameter int ADDRW = AES_ADDRW,
  parameter int DEPTH = 4
);

  localparam int INSTRW = instr_width(ADDRW);
  localparam int CNTW   = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              flush;
  logic              req_valid;
  logic [INSTRW-1:0] req_data;
  logic              ready_req_in;
  logic [CNTW-1:0]   count;
  logic              partial;

  modport master (
    output in_valid, in_data, flush, ready_req_in,
    input  in_ready, req_valid, req_data, count, partial
  );

  modport slave (
    input  in_valid, in_data, flush, ready_req_in,
    output in_ready, req_valid, req_data, count, partial
  );

endinterface : aes_req_queue_if

`default_nettype wire

// File: rtl/aes_req_queue_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered storage, occupancy count
//               and a synchronous flush that overrides push/pop. The head
//               entry reads as zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_count = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Overflow/underflow protection: ignore push when full, pop when empty
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full    = (r_count == c_full_count);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; flush wins over a same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written at the write pointer on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

endmodule : sync_fifo

`default_nettype wire

// File: rtl/aes_req_queue.sv
// ============================================================================
// Module      : aes_req_queue
// Description : Upstream request stage for aes_fsm. Assembles MSB-first host
//               bytes into full AES instructions and queues them for the
//               valid/ready request handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_req_queue
  import aes_pkg::*;
#(
  parameter int ADDRW = AES_ADDRW,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  aes_req_queue_if.slave  bus
);

  localparam int INSTRW = instr_width(ADDRW);
  localparam int NBYTES = nbytes(INSTRW);
  localparam int BCW    = $clog2(NBYTES);
  localparam logic [BCW-1:0] c_last_byte = BCW'(NBYTES - 1);

  // Holds every byte but the final one; the final byte completes the word.
  // Bits shifted out above INSTRW are the discarded top of the first byte.
  logic [INSTRW-9:0]          r_shift;
  logic [BCW-1:0]             r_byte_cnt;
  logic                       w_last;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_empty;
  logic [INSTRW-1:0]          w_instr;

  assign w_last   = (r_byte_cnt == c_last_byte);
  // in_ready only depends on state, never on ready_req_in
  assign bus.in_ready = !w_last || !w_full;
  assign w_accept = bus.in_valid && bus.in_ready && !bus.flush;
  assign w_push   = w_accept && w_last;
  assign w_pop    = bus.req_valid && bus.ready_req_in;
  assign w_instr  = {r_shift, bus.in_data};

  assign bus.partial   = (r_byte_cnt != '0);
  assign bus.req_valid = !w_empty;

  // Byte assembler: shift each accepted byte in, wrap after the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (bus.flush) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (w_accept) begin
      r_shift    <= {r_shift[INSTRW-17:0], bus.in_data};
      r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (INSTRW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.flush),
    .push    (w_push),
    .wr_data (w_instr),
    .pop     (w_pop),
    .rd_data (bus.req_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (bus.count)
  );

endmodule : aes_req_queue

`default_nettype wire

// File: tb/tb_aes_req_queue.sv
// ============================================================================
// Module      : tb_aes_req_queue
// Description : Directed self-checking bench for aes_req_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_req_queue;
  import aes_pkg::*;

  localparam int ADDRW  = 24;
  localparam int DEPTH  = 4;
  localparam int INSTRW = 3 * ADDRW + 2;

  localparam logic [INSTRW-1:0] c_i1 = 74'h2_112233_445566_778899;
  localparam logic [INSTRW-1:0] c_a  = 74'h1_000001_000002_000003;
  localparam logic [INSTRW-1:0] c_b  = 74'h3_aaaaaa_bbbbbb_cccccc;
  localparam logic [INSTRW-1:0] c_c  = 74'h0_123456_789abc_def012;
  localparam logic [INSTRW-1:0] c_d  = 74'h2_fedcba_987654_321001;
  localparam logic [INSTRW-1:0] c_e  = 74'h1_0f0f0f_f0f0f0_5a5a5a;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  aes_req_queue_if #(.ADDRW(ADDRW), .DEPTH(DEPTH)) bus ();

  aes_req_queue #(.ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", {127'd0, bus.in_ready}, 128'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_partial(input logic [INSTRW-1:0] v, input int nb);
    logic [79:0] ext;
    ext = {6'd0, v};
    for (int i = 9; i > 9 - nb; i--) send_byte(ext[8*i +: 8]);
  endtask

  task automatic pop_check(input string tag, input logic [INSTRW-1:0] exp);
    check({tag, "_valid"}, {127'd0, bus.req_valid}, 128'd1);
    check({tag, "_data"}, {54'd0, bus.req_data}, {54'd0, exp});
    bus.ready_req_in = 1'b1;
    tick();
    bus.ready_req_in = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_data      = 8'h00;
    bus.flush        = 1'b0;
    bus.ready_req_in = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req_valid", {127'd0, bus.req_valid}, 128'd0);
    check("rst_count", {125'd0, bus.count}, 128'd0);
    check("rst_partial", {127'd0, bus.partial}, 128'd0);
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check("rst_req_data", {54'd0, bus.req_data}, 128'd0);
    rst_n = 1'b1;
    tick();

    // Basic assembly and one-cycle latency
    send_partial(c_i1, 9);
    check("t1_partial", {127'd0, bus.partial}, 128'd1);
    check("t1_not_yet_valid", {127'd0, bus.req_valid}, 128'd0);
    send_byte(8'h99);
    check("t1_count", {125'd0, bus.count}, 128'd1);
    check("t1_mode", {127'd0, bus.req_data[MODE_BIT]}, 128'd1);
    check("t1_key", {104'd0, bus.req_data[KEY_LSB +: 24]}, 128'h112233);
    check("t1_text", {104'd0, bus.req_data[TEXT_LSB +: 24]}, 128'h445566);
    check("t1_dest", {104'd0, bus.req_data[DEST_LSB +: 24]}, 128'h778899);
    pop_check("t1_pop", c_i1);
    check("t1_empty", {125'd0, bus.count}, 128'd0);

    // Upper 6 bits of the first byte are discarded
    send_byte(8'hFE);
    send_partial({2'b00, 72'h112233_445566_778899}, 10 - 1 + 0 == 9 ? 0 : 0);
    for (int i = 8; i >= 0; i--) begin
      logic [71:0] lo;
      lo = 72'h11_2233_4455_6677_8899;
      send_byte(lo[8*i +: 8]);
    end
    check("t2_top", {126'd0, bus.req_data[INSTRW-1 -: 2]}, 128'd2);
    check("t2_key", {104'd0, bus.req_data[KEY_LSB +: 24]}, 128'h112233);
    pop_check("t2_pop", c_i1);

    // Fill to DEPTH, final byte of a fifth instruction stalls until a pop
    send_partial(c_a, 10);
    send_partial(c_b, 10);
    send_partial(c_c, 10);
    send_partial(c_d, 10);
    check("t3_full_count", {125'd0, bus.count}, 128'd4);
    send_partial(c_e, 9);
    check("t3_partial", {127'd0, bus.partial}, 128'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = c_e[7:0];
    tick();
    tick();
    check("t3_stall_ready", {127'd0, bus.in_ready}, 128'd0);
    check("t3_stall_count", {125'd0, bus.count}, 128'd4);
    bus.ready_req_in = 1'b1;
    tick();
    bus.ready_req_in = 1'b0;
    check("t3_after_pop_count", {125'd0, bus.count}, 128'd3);
    check("t3_after_pop_ready", {127'd0, bus.in_ready}, 128'd1);
    tick();
    bus.in_valid = 1'b0;
    check("t3_refill_count", {125'd0, bus.count}, 128'd4);
    check("t3_refill_partial", {127'd0, bus.partial}, 128'd0);
    pop_check("t3_b", c_b);
    pop_check("t3_c", c_c);
    pop_check("t3_d", c_d);
    pop_check("t3_e", c_e);
    check("t3_drained", {127'd0, bus.req_valid}, 128'd0);

    // Simultaneous push and pop keeps count and order
    send_partial(c_a, 10);
    send_partial(c_b, 10);
    send_partial(c_e, 9);
    bus.in_valid     = 1'b1;
    bus.in_data      = c_e[7:0];
    bus.ready_req_in = 1'b1;
    tick();
    bus.in_valid     = 1'b0;
    bus.ready_req_in = 1'b0;
    check("t4_count", {125'd0, bus.count}, 128'd2);
    pop_check("t4_b", c_b);
    pop_check("t4_e", c_e);
    check("t4_drained", {125'd0, bus.count}, 128'd0);

    // Flush drops a queued entry, the partial word and the presented byte
    send_partial(c_b, 10);
    send_partial(c_a, 5);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    check("t5_partial", {127'd0, bus.partial}, 128'd0);
    check("t5_count", {125'd0, bus.count}, 128'd0);
    check("t5_req_valid", {127'd0, bus.req_valid}, 128'd0);
    check("t5_req_data", {54'd0, bus.req_data}, 128'd0);
    send_partial(c_c, 10);
    pop_check("t5_c", c_c);

    // Asynchronous reset mid-assembly with three entries queued
    send_partial(c_a, 10);
    send_partial(c_b, 10);
    send_partial(c_c, 10);
    send_partial(c_d, 4);
    check("t6_pre_count", {125'd0, bus.count}, 128'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_req_valid", {127'd0, bus.req_valid}, 128'd0);
    check("t6_count", {125'd0, bus.count}, 128'd0);
    check("t6_partial", {127'd0, bus.partial}, 128'd0);
    check("t6_in_ready", {127'd0, bus.in_ready}, 128'd1);
    tick();
    rst_n = 1'b1;
    tick();
    send_partial(c_d, 10);
    pop_check("t6_d", c_d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_aes_req_queue

`default_nettype wire
